// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquad sections sharing one time-multiplexed multiplier-accumulator.
// Samples stream in via valid/ready; coefficients are run-time writable per section.
module iir_biquad_cascade #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DATA_FRAC    = 15,
  parameter int unsigned COEFF_WIDTH  = 20,
  parameter int unsigned COEFF_FRAC   = 18,
  parameter int unsigned NUM_SECTIONS = 3,
  parameter int unsigned ADDR_WIDTH   = $clog2(5 * NUM_SECTIONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic                   bypass,
  input  logic                   clear_state,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   coeff_wr_en,
  input  logic [ADDR_WIDTH-1:0]  coeff_wr_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_wr_data,
  output logic                   coeff_wr_err,
  input  logic [ADDR_WIDTH-1:0]  coeff_rd_addr,
  output logic [COEFF_WIDTH-1:0] coeff_rd_data
);

  localparam int unsigned NUM_COEF  = 5 * NUM_SECTIONS;
  localparam int unsigned SEC_W     = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int unsigned PROD_W    = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned ACC_W     = PROD_W + 3;
  localparam int unsigned PROD_FRAC = DATA_FRAC + COEFF_FRAC;
  // Products carry DATA_FRAC+COEFF_FRAC fraction bits; the output keeps DATA_FRAC.
  localparam int unsigned SHIFT     = PROD_FRAC - DATA_FRAC;

  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0]  Y_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0]  Y_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [COEFF_WIDTH-1:0] B0_ONE = COEFF_WIDTH'(1) << COEFF_FRAC;
  localparam logic [SEC_W-1:0]      LAST_SEC   = SEC_W'(NUM_SECTIONS - 1);
  localparam logic [ADDR_WIDTH-1:0] COEF_LIMIT = ADDR_WIDTH'(NUM_COEF);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t                        r_state;
  logic [SEC_W-1:0]              r_sec;
  logic [2:0]                    r_term;
  logic signed [ACC_W-1:0]       r_acc;
  logic signed [DATA_WIDTH-1:0]  r_x;
  logic                          r_ovf;
  logic                          r_unf;
  logic signed [COEFF_WIDTH-1:0] r_coef [NUM_COEF];
  logic signed [DATA_WIDTH-1:0]  r_x1 [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  r_x2 [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  r_y1 [NUM_SECTIONS];
  logic signed [DATA_WIDTH-1:0]  r_y2 [NUM_SECTIONS];
  logic [DATA_WIDTH-1:0]         r_data_out;
  logic                          r_valid_out;
  logic                          r_overflow;
  logic                          r_underflow;
  logic                          r_wr_err;
  logic                          r_ready;

  logic [ADDR_WIDTH-1:0]         w_coef_idx;
  logic signed [COEFF_WIDTH-1:0] w_coef;
  logic signed [DATA_WIDTH-1:0]  w_op;
  logic signed [PROD_W-1:0]      w_prod;
  logic signed [ACC_W-1:0]       w_round;
  logic                          w_sat_hi;
  logic                          w_sat_lo;
  logic signed [DATA_WIDTH-1:0]  w_y;
  logic                          w_wr_ok;

  assign ready_in     = r_ready;
  assign data_out     = r_data_out;
  assign valid_out    = r_valid_out;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign coeff_wr_err = r_wr_err;
  assign coeff_rd_data = (coeff_rd_addr < COEF_LIMIT) ? r_coef[coeff_rd_addr] : '0;

  // Operand select for the shared multiplier: term order b0*x, b1*x1, b2*x2, a1*y1, a2*y2.
  always_comb begin
    w_coef_idx = ADDR_WIDTH'(5 * 32'(r_sec) + 32'(r_term));
    w_coef     = r_coef[w_coef_idx];
    case (r_term)
      3'd0:    w_op = r_x;
      3'd1:    w_op = r_x1[r_sec];
      3'd2:    w_op = r_x2[r_sec];
      3'd3:    w_op = r_y1[r_sec];
      default: w_op = r_y2[r_sec];
    endcase
    w_prod = PROD_W'(w_op) * PROD_W'(w_coef);
  end

  // Round-half-up and saturate the finished accumulator.
  always_comb begin
    w_round  = (r_acc + ROUND) >>> SHIFT;
    w_sat_hi = (w_round > SAT_MAX);
    w_sat_lo = (w_round < SAT_MIN);
    if (w_sat_hi)      w_y = Y_MAX;
    else if (w_sat_lo) w_y = Y_MIN;
    else               w_y = DATA_WIDTH'(w_round);
  end

  assign w_wr_ok = coeff_wr_en && (r_state == S_IDLE) && (coeff_wr_addr < COEF_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sec       <= '0;
      r_term      <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_wr_err    <= 1'b0;
      r_ready     <= 1'b1;
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        r_coef[i] <= (i % 5 == 0) ? B0_ONE : '0;
      end
      for (int unsigned s = 0; s < NUM_SECTIONS; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
    end else begin
      r_valid_out <= 1'b0;
      r_wr_err    <= coeff_wr_en && !w_wr_ok;
      if (w_wr_ok) r_coef[coeff_wr_addr] <= coeff_wr_data;

      if (clear_state) begin
        // Flush discards any in-flight sample; coefficients survive.
        r_state <= S_IDLE;
        r_ready <= 1'b1;
        for (int unsigned s = 0; s < NUM_SECTIONS; s++) begin
          r_x1[s] <= '0;
          r_x2[s] <= '0;
          r_y1[s] <= '0;
          r_y2[s] <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (valid_in) begin
              r_x     <= data_in;
              r_ovf   <= 1'b0;
              r_unf   <= 1'b0;
              r_sec   <= '0;
              r_term  <= '0;
              r_ready <= 1'b0;
              r_state <= bypass ? S_DONE : S_MAC;
            end
          end
          S_MAC: begin
            if (r_term == 3'd0)     r_acc <= ACC_W'(w_prod);
            else if (r_term < 3'd3) r_acc <= r_acc + ACC_W'(w_prod);
            else                    r_acc <= r_acc - ACC_W'(w_prod);
            if (r_term == 3'd4) r_state <= S_WB;
            else                r_term  <= r_term + 3'd1;
          end
          S_WB: begin
            r_x1[r_sec] <= r_x;
            r_x2[r_sec] <= r_x1[r_sec];
            r_y1[r_sec] <= w_y;
            r_y2[r_sec] <= r_y1[r_sec];
            // The last section publishes directly so the result appears 6*N edges after acceptance.
            if (r_sec == LAST_SEC) begin
              r_data_out  <= w_y;
              r_overflow  <= r_ovf | w_sat_hi;
              r_underflow <= r_unf | w_sat_lo;
              r_valid_out <= 1'b1;
              r_ready     <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_x     <= w_y;
              r_ovf   <= r_ovf | w_sat_hi;
              r_unf   <= r_unf | w_sat_lo;
              r_sec   <= r_sec + SEC_W'(1);
              r_term  <= '0;
              r_state <= S_MAC;
            end
          end
          S_DONE: begin
            r_data_out  <= r_x;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_valid_out <= 1'b1;
            r_ready     <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Self-checking bench for iir_biquad_cascade: directed cases plus randomized samples
// checked against an arithmetic reference model of the cascade.
module tb_iir_biquad_cascade;

  localparam int DW = 16;
  localparam int CW = 20;
  localparam int N  = 3;
  localparam int NC = 5 * N;
  localparam int AW = $clog2(NC);
  localparam int LAT_FILT = 6 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic          ready_in;
  logic          bypass;
  logic          clear_state;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          overflow;
  logic          underflow;
  logic          coeff_wr_en;
  logic [AW-1:0] coeff_wr_addr;
  logic [CW-1:0] coeff_wr_data;
  logic          coeff_wr_err;
  logic [AW-1:0] coeff_rd_addr;
  logic [CW-1:0] coeff_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  longint m_coef [NC];
  longint m_x1 [N];
  longint m_x2 [N];
  longint m_y1 [N];
  longint m_y2 [N];

  iir_biquad_cascade #(
    .DATA_WIDTH(DW), .DATA_FRAC(15), .COEFF_WIDTH(CW), .COEFF_FRAC(18),
    .NUM_SECTIONS(N), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .bypass(bypass), .clear_state(clear_state), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .overflow(overflow),
    .underflow(underflow), .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr),
    .coeff_wr_data(coeff_wr_data), .coeff_wr_err(coeff_wr_err),
    .coeff_rd_addr(coeff_rd_addr), .coeff_rd_data(coeff_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear_state();
    for (int s = 0; s < N; s++) begin
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) m_coef[i] = (i % 5 == 0) ? 64'sd262144 : 64'sd0;
    model_clear_state();
  endfunction

  // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 per section, rounded half-up then clipped.
  function automatic void model_run(input logic [DW-1:0] din, output logic [DW-1:0] y,
                                    output logic ov, output logic un);
    longint x, acc, r;
    x  = longint'($signed(din));
    ov = 1'b0;
    un = 1'b0;
    for (int s = 0; s < N; s++) begin
      acc = m_coef[5*s] * x + m_coef[5*s+1] * m_x1[s] + m_coef[5*s+2] * m_x2[s]
          - m_coef[5*s+3] * m_y1[s] - m_coef[5*s+4] * m_y2[s];
      r = (acc + 131072) >>> 18;
      if (r > 32767)       begin r = 32767;  ov = 1'b1; end
      else if (r < -32768) begin r = -32768; un = 1'b1; end
      m_x2[s] = m_x1[s]; m_x1[s] = x;
      m_y2[s] = m_y1[s]; m_y1[s] = r;
      x = r;
    end
    y = DW'(x);
  endfunction

  task automatic wr_coef(input int addr, input logic [CW-1:0] val, input logic exp_err);
    @(negedge clk);
    coeff_wr_en   = 1'b1;
    coeff_wr_addr = AW'(addr);
    coeff_wr_data = val;
    @(negedge clk);
    coeff_wr_en = 1'b0;
    check("wr_err", 32'(coeff_wr_err), 32'(exp_err));
    if (!exp_err) m_coef[addr] = longint'($signed(val));
  endtask

  task automatic check_rd(input string tag, input int addr, input logic [CW-1:0] exp);
    coeff_rd_addr = AW'(addr);
    #1;
    check(tag, 32'(coeff_rd_data), 32'(exp));
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    model_clear_state();
  endtask

  // Push one sample, wait (bounded) for valid_out, check result, flags and latency against the model.
  task automatic run_sample(input string tag, input logic [DW-1:0] din, input logic byp,
                            output logic [DW-1:0] dout, output logic ov, output logic un);
    logic [DW-1:0] ey;
    logic eo, eu;
    int lat;
    if (byp) begin ey = din; eo = 1'b0; eu = 1'b0; end
    else model_run(din, ey, eo, eu);
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready_in), 32'd1);
    valid_in = 1'b1;
    data_in  = din;
    bypass   = byp;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    bypass   = 1'b0;
    lat = 0;
    while (!valid_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    dout = data_out;
    ov   = overflow;
    un   = underflow;
    check({tag, "_lat"}, 32'(lat), byp ? 32'd1 : 32'(LAT_FILT));
    check({tag, "_data"}, 32'(dout), 32'(ey));
    check({tag, "_flags"}, {30'd0, ov, un}, {30'd0, eo, eu});
  endtask

  task automatic run_exp(input string tag, input logic [DW-1:0] din, input logic byp,
                         input logic [DW-1:0] exp_y, input logic exp_ov, input logic exp_un);
    logic [DW-1:0] y;
    logic ov, un;
    run_sample(tag, din, byp, y, ov, un);
    check({tag, "_const"}, {15'd0, ov, un, y}, {15'd0, exp_ov, exp_un, exp_y});
  endtask

  initial begin
    logic [DW-1:0] ey, prev, y;
    logic eo, eu, ov, un, seen;
    int cnt;

    rst_n = 1'b0; valid_in = 1'b0; bypass = 1'b0; clear_state = 1'b0;
    data_in = '0; coeff_wr_en = 1'b0; coeff_wr_addr = '0; coeff_wr_data = '0;
    coeff_rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_ctrl", {27'd0, valid_out, overflow, underflow, coeff_wr_err, ready_in}, 32'h1);
    check_rd("rst_b0", 0, 20'h40000);
    check_rd("rst_a1", 3, 20'h0);
    rst_n = 1'b1;

    run_exp("identity", 16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);

    do_clear();
    wr_coef(0, 20'h0, 1'b0);
    wr_coef(1, 20'h40000, 1'b0);
    check_rd("rd_b1", 1, 20'h40000);
    run_exp("delay0", 16'h4000, 1'b0, 16'h0000, 1'b0, 1'b0);
    run_exp("delay1", 16'h0000, 1'b0, 16'h4000, 1'b0, 1'b0);
    run_exp("delay2", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    do_clear();
    wr_coef(1, 20'h0, 1'b0);
    wr_coef(0, 20'h40000, 1'b0);
    wr_coef(3, 20'hE0000, 1'b0);
    run_exp("fb0", 16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);
    run_exp("fb1", 16'h0000, 1'b0, 16'h2000, 1'b0, 1'b0);
    run_exp("fb2", 16'h0000, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_exp("fb3", 16'h0000, 1'b0, 16'h0800, 1'b0, 1'b0);

    // Abort an in-flight sample with clear_state.
    @(negedge clk);
    valid_in = 1'b1; data_in = 16'h7000;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    check("clr_ready", 32'(ready_in), 32'd1);
    check("clr_vout", 32'(valid_out), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid_out) seen = 1'b1;
    end
    check("clr_no_vout", 32'(seen), 32'd0);
    model_clear_state();
    run_exp("clr_fb0", 16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);
    run_exp("clr_fb1", 16'h0000, 1'b0, 16'h2000, 1'b0, 1'b0);

    do_clear();
    wr_coef(3, 20'h0, 1'b0);
    wr_coef(0, 20'h7FFFF, 1'b0);
    run_exp("sat_hi", 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, 1'b0);
    run_exp("sat_lo", 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_clear();
    run_exp("sat_none", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Coefficient write while busy is rejected and output holds.
    prev = data_out;
    model_run(16'h1000, ey, eo, eu);
    @(negedge clk);
    valid_in = 1'b1; data_in = 16'h1000;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    coeff_wr_en = 1'b1; coeff_wr_addr = AW'(0); coeff_wr_data = 20'h12345;
    @(negedge clk);
    coeff_wr_en = 1'b0;
    check("busy_err", 32'(coeff_wr_err), 32'd1);
    check("busy_ready", 32'(ready_in), 32'd0);
    check("busy_hold", 32'(data_out), 32'(prev));
    check_rd("busy_rd", 0, 20'h7FFFF);
    @(negedge clk);
    check("busy_err_pulse", 32'(coeff_wr_err), 32'd0);
    cnt = 0;
    while (!valid_out && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_data", 32'(data_out), 32'(ey));
    check("busy_const", 32'(data_out), 32'h2000);

    wr_coef(15, 20'h11111, 1'b1);
    check_rd("rd_oor", 15, 20'h0);
    wr_coef(14, 20'h0, 1'b0);

    // Bypass leaves delay lines untouched.
    do_clear();
    wr_coef(0, 20'h40000, 1'b0);
    wr_coef(3, 20'hE0000, 1'b0);
    run_exp("byp_pre", 16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);
    run_exp("bypass", 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0);
    run_exp("byp_post", 16'h0000, 1'b0, 16'h2000, 1'b0, 1'b0);

    // Reset mid-operation restores everything including coefficients.
    @(negedge clk);
    valid_in = 1'b1; data_in = 16'h3000;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_ctrl", {27'd0, valid_out, overflow, underflow, coeff_wr_err, ready_in}, 32'h1);
    check_rd("mid_rst_b0", 0, 20'h40000);
    check_rd("mid_rst_a1", 3, 20'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_exp("post_rst", 16'h4000, 1'b0, 16'h4000, 1'b0, 1'b0);

    // Randomized coefficients, samples and bypass against the model.
    for (int blk = 0; blk < 4; blk++) begin
      for (int a = 0; a < NC; a++) begin
        int v;
        v = (blk == 3) ? int'($urandom_range(0, 32'hFFFFF)) - 32'sh80000
                       : int'($urandom_range(0, 32'h5FFFF)) - 32'sh30000;
        wr_coef(a, CW'(v), 1'b0);
      end
      for (int k = 0; k < 12; k++) begin
        run_sample("rnd", DW'($urandom), ($urandom_range(0, 5) == 0), y, ov, un);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
